// File: rtl/minicpu_pkg.sv
// Shared MiniCPU definitions: control-flow op encodings, comparator mask
// constants and the branch unit state enum.
package minicpu_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_BGE = 2'b01;
   localparam logic [1:0] OP_BLT = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   localparam logic [7:0] MASK_TRUE  = 8'hFF;
   localparam logic [7:0] MASK_FALSE = 8'h00;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } bu_state_t;

endpackage

// File: rtl/branch_unit_if.sv
// Bundle between the execute stage / fetch and the branch unit.
// Handshake: the fetch side consumes pc on every rising edge where
// pc_valid and fetch_ready are both high; pc is held otherwise.
interface branch_unit_if #(
   parameter int PC_W = 8
);
   logic [7:0]      cmp_mask;
   logic            op_valid;
   logic [1:0]      op_type;
   logic [PC_W-1:0] target;
   logic            halt;
   logic            fetch_ready;
   logic [PC_W-1:0] pc;
   logic            pc_valid;
   logic            flush;
   logic            taken;
   logic            mask_err;

   modport master (
      output cmp_mask, op_valid, op_type, target, halt, fetch_ready,
      input  pc, pc_valid, flush, taken, mask_err
   );

   modport slave (
      input  cmp_mask, op_valid, op_type, target, halt, fetch_ready,
      output pc, pc_valid, flush, taken, mask_err
   );
endinterface

// File: rtl/branch_resolve.sv
// Combinational branch predicate: decides taken / malformed-mask from the
// op and the comparator's all-ones / all-zeros result mask.
module branch_resolve
   import minicpu_pkg::*;
(
   input  logic       op_valid,
   input  logic [1:0] op_type,
   input  logic [7:0] cmp_mask,
   output logic       taken_c,
   output logic       mask_bad_c
);

   logic w_mask_true;
   logic w_mask_false;

   assign w_mask_true  = (cmp_mask == MASK_TRUE);
   assign w_mask_false = (cmp_mask == MASK_FALSE);

   // Resolve the op; a mask that is neither all-ones nor all-zeros never
   // takes a conditional branch and is flagged instead.
   always_comb begin
      taken_c    = 1'b0;
      mask_bad_c = 1'b0;
      if (op_valid) begin
         case (op_type)
            OP_BGE: begin
               taken_c    = w_mask_true;
               mask_bad_c = !(w_mask_true || w_mask_false);
            end
            OP_BLT: begin
               taken_c    = w_mask_false;
               mask_bad_c = !(w_mask_true || w_mask_false);
            end
            OP_JMP:  taken_c = 1'b1;
            default: taken_c = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_unit.sv
// Program-counter sequencer: owns the fetch PC, applies taken branches,
// emits a flush bubble after each taken branch and honours halt requests.
module branch_unit
   import minicpu_pkg::*;
#(
   parameter int              PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   branch_unit_if.slave  bus,
   output bu_state_t     o_dbg_state
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   bu_state_t       r_state;
   bu_state_t       w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [2:0]      r_flush_cnt;
   logic [2:0]      w_flush_cnt_nxt;
   logic            r_pc_valid;
   logic            r_flush;
   logic            r_taken;
   logic            r_mask_err;
   logic            w_taken_c;
   logic            w_mask_bad_c;
   logic            w_take;
   logic            w_mask_set;

   branch_resolve u_resolve (
      .op_valid   (bus.op_valid),
      .op_type    (bus.op_type),
      .cmp_mask   (bus.cmp_mask),
      .taken_c    (w_taken_c),
      .mask_bad_c (w_mask_bad_c)
   );

   // Next state / PC / flush count. The flush counter runs on its own so the
   // flush pulse keeps its full length even when halt diverts the FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_take          = 1'b0;
      w_mask_set      = 1'b0;
      w_flush_cnt_nxt = (r_flush_cnt != 3'd0) ? (r_flush_cnt - 3'd1) : 3'd0;
      case (r_state)
         ST_RUN: begin
            w_mask_set = w_mask_bad_c;
            if (w_taken_c) begin
               w_take          = 1'b1;
               w_pc_nxt        = bus.target;
               w_flush_cnt_nxt = FLUSH_INIT;
               w_state_nxt     = bus.halt ? ST_HALTED : ST_FLUSH;
            end else if (bus.halt) begin
               w_state_nxt = ST_HALTED;
            end else if (r_pc_valid && bus.fetch_ready) begin
               w_pc_nxt = r_pc + PC_W'(1);
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt <= 3'd1) begin
               w_state_nxt = bus.halt ? ST_HALTED : ST_RUN;
            end
         end
         ST_HALTED: begin
            if (!bus.halt) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // State and registered outputs; reset abandons any pending flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_pc        <= RESET_PC;
         r_flush_cnt <= 3'd0;
         r_pc_valid  <= 1'b0;
         r_flush     <= 1'b0;
         r_taken     <= 1'b0;
         r_mask_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_pc_valid  <= (w_state_nxt == ST_RUN);
         r_flush     <= (w_flush_cnt_nxt != 3'd0);
         r_taken     <= w_take;
         if (w_mask_set) begin
            r_mask_err <= 1'b1;
         end
      end
   end

   assign bus.pc       = r_pc;
   assign bus.pc_valid = r_pc_valid;
   assign bus.flush    = r_flush;
   assign bus.taken    = r_taken;
   assign bus.mask_err = r_mask_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vector table with hand-derived results,
// then randomized traffic against a cycle-level behavioural model.
module tb_branch_unit;
   import minicpu_pkg::*;

   localparam int PC_W = 8;
   localparam int FC   = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_unit_if #(.PC_W(PC_W)) bus ();
   bu_state_t dbg_state;

   branch_unit #(
      .PC_W         (PC_W),
      .RESET_PC     (8'h00),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst_n;
      logic       ov;
      logic [1:0] ot;
      logic [7:0] mask;
      logic [7:0] tgt;
      logic       halt;
      logic       fr;
      logic [7:0] e_pc;
      logic       e_v;
      logic       e_f;
      logic       e_t;
      logic       e_e;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic ov, logic [1:0] ot, logic [7:0] mask,
                               logic [7:0] tgt, logic halt, logic fr, logic [7:0] e_pc,
                               logic e_v, logic e_f, logic e_t, logic e_e);
      vec_t v;
      v.rst_n = r;   v.ov = ov;     v.ot = ot;     v.mask = mask; v.tgt = tgt;
      v.halt = halt; v.fr = fr;     v.e_pc = e_pc; v.e_v = e_v;   v.e_f = e_f;
      v.e_t = e_t;   v.e_e = e_e;
      return v;
   endfunction

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // bubble: remaining fetch-suppressed cycles after a taken branch
   // fl: remaining cycles of the flush pulse (keeps counting while halted)
   int m_pc, m_bubble, m_fl;
   bit m_halted, m_err, m_tk, m_pcv, m_fresh;

   function automatic void model_step(logic r, logic ov, logic [1:0] ot, logic [7:0] mask,
                                      logic [7:0] tgt, logic halt, logic fr);
      bit active, tk, bad, cond;
      if (!r) begin
         m_pc = 0; m_bubble = 0; m_fl = 0; m_halted = 0;
         m_err = 0; m_tk = 0; m_pcv = 0;
         return;
      end
      active = (m_bubble == 0) && !m_halted;
      cond   = (ot == 2'b11) || (ot == 2'b01 && mask == 8'hFF) || (ot == 2'b10 && mask == 8'h00);
      tk     = active && ov && cond;
      bad    = active && ov && (ot == 2'b01 || ot == 2'b10) && mask != 8'h00 && mask != 8'hFF;
      if (bad) m_err = 1;
      m_fl = tk ? FC : ((m_fl > 0) ? m_fl - 1 : 0);
      if (active) begin
         if (tk) begin
            m_pc = tgt;
            if (halt) m_halted = 1;
            else      m_bubble = FC;
         end else if (halt) begin
            m_halted = 1;
         end else if (m_pcv && fr) begin
            m_pc = (m_pc + 1) % 256;
         end
      end else if (m_bubble > 0) begin
         m_bubble--;
         if (m_bubble == 0 && halt) m_halted = 1;
      end else if (!halt) begin
         m_halted = 0;
      end
      m_pcv = (m_bubble == 0) && !m_halted;
      m_tk  = tk;
   endfunction

   // ---------------- driver ----------------
   // Inputs change on the falling edge; outputs are sampled on the next one.
   task automatic drive(logic r, logic ov, logic [1:0] ot, logic [7:0] mask,
                        logic [7:0] tgt, logic halt, logic fr);
      rst_n           = r;
      bus.op_valid    = ov;
      bus.op_type     = ot;
      bus.cmp_mask    = mask;
      bus.target      = tgt;
      bus.halt        = halt;
      bus.fetch_ready = fr;
      @(posedge clk);
      @(negedge clk);
      model_step(r, ov, ot, mask, tgt, halt, fr);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.op_valid = 0; bus.op_type = 0; bus.cmp_mask = 0; bus.target = 0;
      bus.halt = 0; bus.fetch_ready = 0;
      @(negedge clk);

      //                r  ov ot     mask   tgt    h  fr  e_pc   v  f  t  e
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0)); // first edge
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h01, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h02, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h03, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h04, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h05, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd1, 8'hFF, 8'h40, 0, 1, 8'h40, 0, 1, 1, 0)); // BGE taken
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h40, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h40, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h41, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd2, 8'hFF, 8'h40, 0, 0, 8'h41, 1, 0, 0, 0)); // BLT not taken, stall
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 0, 8'h41, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h42, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd1, 8'h0F, 8'h40, 0, 1, 8'h43, 1, 0, 0, 1)); // malformed mask
      tbl.push_back(mk(1, 1, 2'd3, 8'h00, 8'h10, 0, 1, 8'h10, 0, 1, 1, 1)); // JMP, err sticky
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h10, 0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h10, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h11, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'd3, 8'h00, 8'h80, 1, 1, 8'h80, 0, 1, 1, 1)); // JMP + halt
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 1, 1, 8'h80, 0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 1, 1, 8'h80, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h80, 1, 0, 0, 1)); // halt released
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h81, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'd3, 8'h00, 8'h20, 0, 1, 8'h20, 0, 1, 1, 1)); // JMP
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0)); // reset during flush
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h01, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd3, 8'h00, 8'hFE, 0, 1, 8'hFE, 0, 1, 1, 0)); // JMP near top
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'hFE, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'hFE, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'hFF, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0)); // wrap
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h01, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd2, 8'h00, 8'h33, 0, 1, 8'h33, 0, 1, 1, 0)); // BLT taken
      tbl.push_back(mk(1, 1, 2'd3, 8'h00, 8'h77, 0, 1, 8'h33, 0, 1, 0, 0)); // ignored in flush
      tbl.push_back(mk(1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 8'h33, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'd0, 8'h0F, 8'h00, 0, 1, 8'h34, 1, 0, 0, 0)); // NOP mask unchecked
      tbl.push_back(mk(1, 1, 2'd3, 8'h5A, 8'h00, 0, 1, 8'h00, 0, 1, 1, 0)); // JMP mask unchecked

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].ov, tbl[i].ot, tbl[i].mask, tbl[i].tgt,
               tbl[i].halt, tbl[i].fr);
         check($sformatf("v%0d_pc", i),       32'(bus.pc),       32'(tbl[i].e_pc));
         check($sformatf("v%0d_pc_valid", i), 32'(bus.pc_valid), 32'(tbl[i].e_v));
         check($sformatf("v%0d_flush", i),    32'(bus.flush),    32'(tbl[i].e_f));
         check($sformatf("v%0d_taken", i),    32'(bus.taken),    32'(tbl[i].e_t));
         check($sformatf("v%0d_mask_err", i), 32'(bus.mask_err), 32'(tbl[i].e_e));
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic       r, ov, h, fr;
         logic [1:0] ot;
         logic [7:0] mask, tgt;
         r   = ($urandom_range(0, 79) != 0);
         ov  = ($urandom_range(0, 1) == 1);
         ot  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       mask = 8'hFF;
            1:       mask = 8'h00;
            2:       mask = 8'($urandom_range(0, 255));
            default: mask = 8'hFF;
         endcase
         tgt = 8'($urandom_range(0, 255));
         h   = ($urandom_range(0, 9) == 0);
         fr  = ($urandom_range(0, 3) != 0);
         drive(r, ov, ot, mask, tgt, h, fr);
         check($sformatf("r%0d_pc", c),       32'(bus.pc),       32'(m_pc));
         check($sformatf("r%0d_pc_valid", c), 32'(bus.pc_valid), 32'(m_pcv));
         check($sformatf("r%0d_flush", c),    32'(bus.flush),    32'(m_fl != 0));
         check($sformatf("r%0d_taken", c),    32'(bus.taken),    32'(m_tk));
         check($sformatf("r%0d_mask_err", c), 32'(bus.mask_err), 32'(m_err));
      end

      // ---------------- report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
# branch_unit

Conditional branch / program-counter sequencer of the MiniCPU execute path, directly downstream of the comparator. It consumes the comparator's 8-bit all-ones/all-zeros result mask and resolves BGE/BLT/JMP control-flow ops. It owns the fetch PC, squashes wrong-path fetches after a taken branch, and supports a halt request.

## Interface
Parameters:
- PC_W, 8: PC and target width.
- RESET_PC, 8'h00: PC value loaded by reset.
- FLUSH_CYCLES, 2: bubble length after a taken branch; legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- cmp_mask  in  8  comparator result: 8'hFF means A>=B, 8'h00 means A<B.
- op_valid  in  1  a control-flow op is presented this cycle.
- op_type  in  2  00 NOP, 01 BGE (taken if mask FF), 10 BLT (taken if mask 00), 11 JMP (always taken).
- target  in  PC_W  absolute branch target.
- halt  in  1  level request to stop fetching.
- fetch_ready  in  1  fetch accepts the current PC.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- flush  out  1  squash instructions already fetched on the wrong path.
- taken  out  1  one-cycle pulse: a branch was taken.
- mask_err  out  1  sticky: a malformed mask was seen on BGE/BLT.

## Operation
- FSM states: RUN, FLUSH, HALTED. Reset state is RUN.
- Resolution: taken = op_valid and one of:
  - op_type is JMP;
  - op_type is BGE and mask is FF;
  - op_type is BLT and mask is 00.
- Malformed mask: any value other than 00/FF on BGE/BLT is not taken and sets mask_err. mask_err clears only on reset. The mask is not checked for NOP or JMP.
- RUN:
  - taken: pc<=target, flush counter<=FLUSH_CYCLES, go to FLUSH.
  - not taken, pc_valid && fetch_ready: pc<=pc+1. Wraps modulo 2^PC_W (FF->00).
  - not taken, fetch_ready low: pc holds.
  - Branch resolution does not depend on fetch_ready.
- FLUSH:
  - op_valid is ignored; pc holds.
  - Counter decrements each cycle; at 1, go to RUN (or HALTED if halt is high).
- HALTED: pc holds; op_valid is ignored. Go to RUN in the cycle after halt is sampled low.
- halt in RUN without taken: go to HALTED; pc holds.
- halt together with taken: pc<=target, go to HALTED. Halt overrides FLUSH, but flush/taken still pulse for FLUSH_CYCLES.
- Reset mid-operation: rst_n low in any state forces the reset values next edge and abandons the pending flush count.

## Timing
- All outputs registered.
- Reset values: pc=RESET_PC, pc_valid=0, flush=0, taken=0, mask_err=0.
- pc_valid = (state==RUN). It rises on the first edge after rst_n goes high.
- Branch presented in cycle N:
  - N+1: pc=target, taken=1 for one cycle, flush=1.
  - flush stays high for FLUSH_CYCLES cycles, N+1..N+FLUSH_CYCLES.
  - pc_valid low for those same cycles, high again at N+1+FLUSH_CYCLES (if not halted).
- mask_err: sets at N+1 for a malformed mask sampled at N.
- Sequential fetch throughput: one PC per cycle while fetch_ready is high.

## Structure
- Shared package minicpu_pkg holds:
  - op_type encodings (OP_NOP, OP_BGE, OP_BLT, OP_JMP);
  - mask constants (MASK_TRUE=8'hFF, MASK_FALSE=8'h00);
  - the branch_unit state enum.
- One combinational sub-module, branch_resolve. Inputs: op_valid, op_type, cmp_mask. Outputs: taken_c, mask_bad_c. Reused by a future writeback predicate.
- PC register, flush counter (3 bits) and FSM live in branch_unit.

## Test plan
- Reset then run: rst_n low 2 cycles, then high with fetch_ready=1 -> pc 00,01,02… one per cycle; pc_valid=1 from the first post-reset edge; at FF pc wraps to 00.
- BGE taken: pc=05, op_valid=1, BGE, mask FF, target 40 -> next cycle pc=40, taken pulse 1 cycle, flush and pc_valid=0 for 2 cycles, then pc 40,41…
- BLT not taken with backpressure: mask FF, BLT, target 40, fetch_ready=0 -> no taken, no flush, pc holds; pc increments only once fetch_ready=1.
- Malformed mask: BGE with mask 8'h0F -> not taken, pc increments, mask_err=1 next cycle and stays 1 through later JMPs until reset.
- Halt with JMP to 80: same-cycle halt=1 -> pc=80, flush for FLUSH_CYCLES, pc_valid=0 while halt held; halt low -> pc_valid=1 next cycle at pc 80.
- Reset during FLUSH: JMP then rst_n low at the next cycle -> pc=00, flush=0, pc_valid=0, state RUN after release.
